mem_access_unit: RTL and testbench
==================================

# mem_access_unit

- Memory-stage controller that sits directly after the EX/MEM pipeline register.
- Consumes the memory-access fields that register carries, runs a request/acknowledge transaction on the data bus, and stalls the upstream pipeline until the bus answers.
- Selects the write-back value and registers it into the MEM/WB fields it drives.
- Flags misaligned, conflicting and timed-out accesses without touching the bus.

## Interface

- TIMEOUT, 16: cycles in REQ without ack before the access is abandoned; legal range 2..255.
- clk  input  1  pipeline clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- EX_MEM_mem_rd  input  1  load request.
- EX_MEM_mem_wr  input  1  store request.
- EX_MEM_mem_rd_addr  input  32  load byte address.
- EX_MEM_mem_wr_addr  input  32  store byte address.
- EX_MEM_mem_wr_data  input  32  store data, already forwarded.
- EX_MEM_ALU_out  input  32  ALU result.
- EX_MEM_mem_to_reg  input  2  write-back select:
  - 0: ALU_out.
  - 1: memory data.
  - 2: PC_plus_8.
  - 3: ALU_out.
- EX_MEM_reg_wr  input  1  register write enable.
- EX_MEM_reg_wr_addr  input  5  destination register.
- EX_MEM_PC_plus_8  input  32  link value.
- dbus_req  output  1  bus request; registered.
- dbus_we  output  1  1 = store; registered.
- dbus_addr  output  32  word-aligned address; registered.
- dbus_wdata  output  32  store data; registered.
- dbus_ack  input  1  bus completion, single-cycle pulse.
- dbus_rdata  input  32  load data, valid when dbus_ack = 1.
- mem_stall  output  1  freezes PC, IF/ID, ID/EX and EX/MEM; combinational.
- mem_fault  output  1  one-cycle pulse on any fault; registered.
- MEM_WB_reg_wr  output  1  write-back enable.
- MEM_WB_reg_wr_addr  output  5  write-back register.
- MEM_WB_wb_data  output  32  write-back value.

## Operation

- Two-state FSM.
- **IDLE**: define `acc = EX_MEM_mem_rd | EX_MEM_mem_wr`.
  - Address is `EX_MEM_mem_wr_addr` when `mem_wr`, otherwise `EX_MEM_mem_rd_addr`.
  - Valid access (`acc`, exactly one of rd/wr, `addr[1:0] == 0`):
    - load dbus_addr, dbus_we and dbus_wdata;
    - set dbus_req;
    - go to REQ;
    - clear the timeout counter.
  - Fault case (rd and wr both 1, or `addr[1:0] != 0`):
    - no bus access;
    - mem_fault pulses next cycle;
    - MEM_WB_reg_wr is written 0;
    - no stall.
  - Neither rd nor wr: pass-through; MEM/WB captures the selected value.
- **REQ**: dbus_req, dbus_addr, dbus_we and dbus_wdata stay constant.
  - dbus_ack = 1:
    - clear dbus_req;
    - go to IDLE;
    - MEM/WB captures, using dbus_rdata when mem_to_reg = 1.
  - dbus_ack = 0 and counter = TIMEOUT-1:
    - clear dbus_req;
    - go to IDLE;
    - pulse mem_fault;
    - MEM_WB_reg_wr written 0.
  - Otherwise: increment the counter.
- mem_stall = (IDLE & valid access) | (REQ & ~dbus_ack & ~timeout_hit).
- MEM/WB update:
  - While mem_stall = 1, MEM/WB loads a bubble: reg_wr = 0; addr and data hold.
  - When not stalled, it loads reg_wr, reg_wr_addr and the selected data.
  - A store's reg_wr is passed through unchanged; the decoder clears it.
- dbus_ack received in IDLE is ignored.

## Timing

- Reset (reset = 0, asynchronous):
  - state IDLE;
  - dbus_req, dbus_we, dbus_addr, dbus_wdata = 0;
  - mem_fault = 0;
  - MEM_WB_reg_wr, MEM_WB_reg_wr_addr, MEM_WB_wb_data = 0;
  - counter = 0.
- Reset mid-REQ drops dbus_req immediately; the transaction is abandoned.
- Non-memory instruction: 1 cycle, no stall.
- Access, detection cycle N:
  - mem_stall = 1 in cycle N;
  - dbus_req = 1 from cycle N+1;
  - with ack in cycle N+k, mem_stall = 0 in cycle N+k;
  - MEM/WB valid at edge N+k+1;
  - minimum access latency is 2 cycles (k = 1).
- Timeout:
  - dbus_req is high for exactly TIMEOUT cycles;
  - stall releases in the last of those cycles;
  - mem_fault is high the following cycle.
- Ack in the same cycle the counter hits TIMEOUT-1: ack wins, no fault.
- Back-to-back accesses: IDLE re-detects in the cycle after release; there is always one cycle with dbus_req = 0 between transactions.

## Test plan

- Reset mid-REQ:
  - stimulus: reset = 0 while dbus_req = 1;
  - required: all outputs 0 asynchronously; after release, a new load proceeds normally.
- Load:
  - stimulus: rd = 1, rd_addr = 0x0000_0010, mem_to_reg = 1, reg_wr_addr = 8; ack 3 cycles after req with rdata = 0xDEAD_BEEF;
  - required: stall for 4 cycles; dbus_addr = 0x10, dbus_we = 0; MEM_WB_wb_data = 0xDEAD_BEEF, MEM_WB_reg_wr_addr = 8, MEM_WB_reg_wr = 1 once.
- Store:
  - stimulus: wr = 1, wr_addr = 0x20, wr_data = 0x1234_5678; ack 1 cycle after req;
  - required: dbus_we = 1, dbus_wdata = 0x1234_5678; stall for exactly 2 cycles.
- Misaligned:
  - stimulus: rd = 1, rd_addr = 0x13;
  - required: dbus_req stays 0, no stall, mem_fault = 1 for one cycle, MEM_WB_reg_wr = 0.
- Timeout:
  - stimulus: TIMEOUT = 4, load, no ack;
  - required: dbus_req high for 4 cycles; mem_fault pulse; MEM_WB_reg_wr = 0; next instruction then proceeds.
- Pass-through and stray ack:
  - stimulus: mem_to_reg = 2, PC_plus_8 = 0x400, reg_wr = 1; dbus_ack = 1 while in IDLE;
  - required: MEM_WB_wb_data = 0x400, no stall; the stray ack is ignored.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage controller sitting after the EX/MEM register.
// It runs one request/acknowledge transaction per load or store on the data
// bus and stalls the upstream pipeline until the bus answers.
// It selects the write-back value and registers it into the MEM/WB fields.
// Misaligned, conflicting (rd and wr together) and timed-out accesses raise a
// one-cycle mem_fault and squash the register write.
module mem_access_unit #(
  parameter int TIMEOUT = 16  // cycles in REQ without ack before abandoning (2..255)
) (
  input  logic        clk,
  input  logic        reset,               // asynchronous, active-low
  input  logic        EX_MEM_mem_rd,
  input  logic        EX_MEM_mem_wr,
  input  logic [31:0] EX_MEM_mem_rd_addr,
  input  logic [31:0] EX_MEM_mem_wr_addr,
  input  logic [31:0] EX_MEM_mem_wr_data,
  input  logic [31:0] EX_MEM_ALU_out,
  input  logic [1:0]  EX_MEM_mem_to_reg,
  input  logic        EX_MEM_reg_wr,
  input  logic [4:0]  EX_MEM_reg_wr_addr,
  input  logic [31:0] EX_MEM_PC_plus_8,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic        mem_stall,
  output logic        mem_fault,
  output logic        MEM_WB_reg_wr,
  output logic [4:0]  MEM_WB_reg_wr_addr,
  output logic [31:0] MEM_WB_wb_data
);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_reg;
  state_t      state_next;
  logic [7:0]  cnt_reg;

  logic        acc;
  logic        conflict;
  logic        misaligned;
  logic        valid_acc;
  logic [31:0] acc_addr;
  logic [31:0] wb_sel;

  logic        start_acc;   // launch a bus transaction at this edge
  logic        end_acc;     // drop dbus_req at this edge
  logic        cnt_inc;     // still waiting in REQ
  logic        fault_now;   // fault detected this cycle, pulse next cycle
  logic        capture;     // MEM/WB takes the instruction this cycle

  // Decode the access fields held in EX/MEM
  always_comb begin
    acc        = EX_MEM_mem_rd | EX_MEM_mem_wr;
    conflict   = EX_MEM_mem_rd & EX_MEM_mem_wr;
    acc_addr   = EX_MEM_mem_wr ? EX_MEM_mem_wr_addr : EX_MEM_mem_rd_addr;
    misaligned = (acc_addr[1:0] != 2'b00);
    valid_acc  = acc & ~conflict & ~misaligned;
  end

  // Write-back source select; memory data only meaningful on the ack cycle
  always_comb begin
    case (EX_MEM_mem_to_reg)
      2'd1:    wb_sel = dbus_rdata;
      2'd2:    wb_sel = EX_MEM_PC_plus_8;
      default: wb_sel = EX_MEM_ALU_out;
    endcase
  end

  // Next-state and control decode; ack beats the timeout in the same cycle
  always_comb begin
    state_next = state_reg;
    start_acc  = 1'b0;
    end_acc    = 1'b0;
    cnt_inc    = 1'b0;
    fault_now  = 1'b0;
    capture    = 1'b0;
    mem_stall  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (valid_acc) begin
          state_next = REQ;
          start_acc  = 1'b1;
          mem_stall  = 1'b1;
        end else if (acc) begin
          fault_now = 1'b1;
        end else begin
          capture = 1'b1;
        end
      end
      REQ: begin
        if (dbus_ack) begin
          state_next = IDLE;
          end_acc    = 1'b1;
          capture    = 1'b1;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = IDLE;
          end_acc    = 1'b1;
          fault_now  = 1'b1;
        end else begin
          cnt_inc   = 1'b1;
          mem_stall = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Timeout counter: cleared at launch, counts waiting cycles in REQ
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         cnt_reg <= 8'd0;
    else if (start_acc) cnt_reg <= 8'd0;
    else if (cnt_inc)   cnt_reg <= cnt_reg + 8'd1;
  end

  // Bus request registers; held constant for the whole transaction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= 32'd0;
      dbus_wdata <= 32'd0;
    end else if (start_acc) begin
      dbus_req   <= 1'b1;
      dbus_we    <= EX_MEM_mem_wr;
      dbus_addr  <= {acc_addr[31:2], 2'b00};
      dbus_wdata <= EX_MEM_mem_wr_data;
    end else if (end_acc) begin
      dbus_req   <= 1'b0;
    end
  end

  // Fault pulse, one cycle after detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mem_fault <= 1'b0;
    else        mem_fault <= fault_now;
  end

  // MEM/WB: commit on capture, otherwise insert a bubble and hold addr/data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      MEM_WB_reg_wr      <= 1'b0;
      MEM_WB_reg_wr_addr <= 5'd0;
      MEM_WB_wb_data     <= 32'd0;
    end else if (capture) begin
      MEM_WB_reg_wr      <= EX_MEM_reg_wr;
      MEM_WB_reg_wr_addr <= EX_MEM_reg_wr_addr;
      MEM_WB_wb_data     <= wb_sel;
    end else begin
      MEM_WB_reg_wr      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (TIMEOUT = 4). Inputs are driven 1 ns
// after the rising edge, outputs sampled on the falling edge.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk;
  logic        reset;
  logic        rd, wr;
  logic [31:0] rd_addr, wr_addr, wr_data, alu, pc8;
  logic [1:0]  m2r;
  logic        reg_wr;
  logic [4:0]  reg_wr_addr;
  logic        dbus_req, dbus_we, dbus_ack;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic        mem_stall, mem_fault;
  logic        wb_reg_wr;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int n_cmp = 0;
  int n_mis = 0;
  int stall_seen;
  int req_seen;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk                (clk),
    .reset              (reset),
    .EX_MEM_mem_rd      (rd),
    .EX_MEM_mem_wr      (wr),
    .EX_MEM_mem_rd_addr (rd_addr),
    .EX_MEM_mem_wr_addr (wr_addr),
    .EX_MEM_mem_wr_data (wr_data),
    .EX_MEM_ALU_out     (alu),
    .EX_MEM_mem_to_reg  (m2r),
    .EX_MEM_reg_wr      (reg_wr),
    .EX_MEM_reg_wr_addr (reg_wr_addr),
    .EX_MEM_PC_plus_8   (pc8),
    .dbus_req           (dbus_req),
    .dbus_we            (dbus_we),
    .dbus_addr          (dbus_addr),
    .dbus_wdata         (dbus_wdata),
    .dbus_ack           (dbus_ack),
    .dbus_rdata         (dbus_rdata),
    .mem_stall          (mem_stall),
    .mem_fault          (mem_fault),
    .MEM_WB_reg_wr      (wb_reg_wr),
    .MEM_WB_reg_wr_addr (wb_addr),
    .MEM_WB_wb_data     (wb_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clr();
    rd = 1'b0; wr = 1'b0; rd_addr = '0; wr_addr = '0; wr_data = '0;
    alu = '0; pc8 = '0; m2r = 2'd0; reg_wr = 1'b0; reg_wr_addr = '0;
    dbus_ack = 1'b0; dbus_rdata = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    clr();
    reset = 1'b0;
    #2;
    check("rst_req",    32'(dbus_req), 0);
    check("rst_addr",   dbus_addr, 0);
    check("rst_fault",  32'(mem_fault), 0);
    check("rst_wb_wr",  32'(wb_reg_wr), 0);
    check("rst_wb_dat", wb_data, 0);
    check("rst_stall",  32'(mem_stall), 0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    $display("reset released");

    // ---- load, ack arrives exactly when the counter reaches TIMEOUT-1 ----
    clr(); rd = 1; rd_addr = 32'h10; m2r = 2'd1; reg_wr = 1; reg_wr_addr = 5'd8;
    stall_seen = 0;
    mid(); check("ld_n_stall", 32'(mem_stall), 1); check("ld_n_req", 32'(dbus_req), 0);
    stall_seen += int'(mem_stall); cyc();
    for (int i = 1; i <= 3; i++) begin
      mid();
      check("ld_req", 32'(dbus_req), 1);
      check("ld_addr", dbus_addr, 32'h10);
      check("ld_we", 32'(dbus_we), 0);
      check("ld_bubble", 32'(wb_reg_wr), 0);
      stall_seen += int'(mem_stall);
      cyc();
    end
    dbus_ack = 1; dbus_rdata = 32'hDEAD_BEEF;
    mid(); check("ld_ack_stall", 32'(mem_stall), 0);
    stall_seen += int'(mem_stall);
    check("ld_stall_cycles", stall_seen, 4); cyc();
    clr();
    mid();
    check("ld_req_drop", 32'(dbus_req), 0);
    check("ld_wb_wr", 32'(wb_reg_wr), 1);
    check("ld_wb_data", wb_data, 32'hDEAD_BEEF);
    check("ld_wb_addr", 32'(wb_addr), 8);
    check("ld_no_fault", 32'(mem_fault), 0);
    cyc();
    mid(); check("ld_wr_once", 32'(wb_reg_wr), 0); cyc();
    $display("load 0x10 -> 0xdeadbeef done");

    // ---- store, ack one cycle after req ----
    clr(); wr = 1; wr_addr = 32'h20; wr_data = 32'h1234_5678;
    stall_seen = 0;
    mid(); check("st_n_req", 32'(dbus_req), 0); stall_seen += int'(mem_stall); cyc();
    mid();
    check("st_req", 32'(dbus_req), 1);
    check("st_we", 32'(dbus_we), 1);
    check("st_wdata", dbus_wdata, 32'h1234_5678);
    check("st_addr", dbus_addr, 32'h20);
    stall_seen += int'(mem_stall); cyc();
    dbus_ack = 1;
    mid(); stall_seen += int'(mem_stall);
    check("st_stall_cycles", stall_seen, 2); cyc();
    clr();
    mid(); check("st_req_drop", 32'(dbus_req), 0); check("st_no_fault", 32'(mem_fault), 0); cyc();
    $display("store 0x20 <- 0x12345678 done");

    // ---- pass-through of PC+8 with a stray ack in IDLE ----
    clr(); m2r = 2'd2; pc8 = 32'h400; reg_wr = 1; reg_wr_addr = 5'd3; dbus_ack = 1;
    mid(); check("pt_stall", 32'(mem_stall), 0); check("pt_req", 32'(dbus_req), 0); cyc();
    $display("pass-through pc+8 with stray ack");

    // ---- misaligned load ----
    clr(); rd = 1; rd_addr = 32'h13; reg_wr = 1; reg_wr_addr = 5'd5;
    mid();
    check("pt_wb_data", wb_data, 32'h400);
    check("pt_wb_wr", 32'(wb_reg_wr), 1);
    check("pt_wb_addr", 32'(wb_addr), 3);
    check("mis_stall", 32'(mem_stall), 0);
    check("mis_req", 32'(dbus_req), 0);
    cyc();
    clr(); m2r = 2'd0; alu = 32'hA5A5_0001; reg_wr = 1; reg_wr_addr = 5'd6;
    mid();
    check("mis_fault", 32'(mem_fault), 1);
    check("mis_wb_wr", 32'(wb_reg_wr), 0);
    check("mis_req2", 32'(dbus_req), 0);
    cyc();
    $display("misaligned load 0x13 faulted");

    // ---- rd and wr together ----
    clr(); rd = 1; wr = 1; rd_addr = 32'h100; wr_addr = 32'h104; reg_wr = 1; reg_wr_addr = 5'd7;
    mid();
    check("mis_fault_end", 32'(mem_fault), 0);
    check("alu0_wb_data", wb_data, 32'hA5A5_0001);
    check("alu0_wb_wr", 32'(wb_reg_wr), 1);
    check("alu0_wb_addr", 32'(wb_addr), 6);
    check("both_stall", 32'(mem_stall), 0);
    cyc();
    clr(); m2r = 2'd3; alu = 32'h0BAD_F00D; reg_wr = 1; reg_wr_addr = 5'd9;
    mid();
    check("both_fault", 32'(mem_fault), 1);
    check("both_wb_wr", 32'(wb_reg_wr), 0);
    check("both_req", 32'(dbus_req), 0);
    cyc();
    clr();
    mid();
    check("both_fault_end", 32'(mem_fault), 0);
    check("alu3_wb_data", wb_data, 32'h0BAD_F00D);
    check("alu3_wb_wr", 32'(wb_reg_wr), 1);
    cyc();
    $display("rd+wr conflict faulted");

    // ---- timeout ----
    clr(); rd = 1; rd_addr = 32'h40; m2r = 2'd1; reg_wr = 1; reg_wr_addr = 5'd9;
    req_seen = 0;
    mid(); check("to_n_stall", 32'(mem_stall), 1); cyc();
    for (int i = 1; i <= TO; i++) begin
      mid();
      req_seen += int'(dbus_req);
      check("to_stall", 32'(mem_stall), (i < TO) ? 32'd1 : 32'd0);
      check("to_fault_low", 32'(mem_fault), 0);
      cyc();
    end
    clr(); m2r = 2'd0; alu = 32'h77; reg_wr = 1; reg_wr_addr = 5'd10;
    mid();
    check("to_req_cycles", req_seen, TO);
    check("to_fault", 32'(mem_fault), 1);
    check("to_req_drop", 32'(dbus_req), 0);
    check("to_wb_wr", 32'(wb_reg_wr), 0);
    check("to_next_stall", 32'(mem_stall), 0);
    cyc();
    clr();
    mid();
    check("to_fault_end", 32'(mem_fault), 0);
    check("to_next_wb_wr", 32'(wb_reg_wr), 1);
    check("to_next_wb_data", wb_data, 32'h77);
    check("to_next_wb_addr", 32'(wb_addr), 10);
    cyc();
    $display("load 0x40 timed out");

    // ---- reset mid-REQ ----
    clr(); rd = 1; rd_addr = 32'h80; m2r = 2'd1; reg_wr = 1; reg_wr_addr = 5'd11;
    mid(); check("rq_n_stall", 32'(mem_stall), 1); cyc();
    mid(); check("rq_req", 32'(dbus_req), 1); check("rq_addr", dbus_addr, 32'h80);
    #1 reset = 1'b0;
    #1;
    check("rq_req_drop", 32'(dbus_req), 0);
    check("rq_addr0", dbus_addr, 0);
    check("rq_we0", 32'(dbus_we), 0);
    check("rq_fault0", 32'(mem_fault), 0);
    check("rq_wb_wr0", 32'(wb_reg_wr), 0);
    check("rq_wb_addr0", 32'(wb_addr), 0);
    check("rq_wb_data0", wb_data, 0);
    clr();
    #1 check("rq_stall0", 32'(mem_stall), 0);
    cyc();
    reset = 1'b1;
    $display("reset during request");

    // ---- minimum-latency load after reset, then back-to-back store ----
    clr(); rd = 1; rd_addr = 32'h84; m2r = 2'd1; reg_wr = 1; reg_wr_addr = 5'd12;
    mid(); check("ml_stall", 32'(mem_stall), 1); check("ml_n_req", 32'(dbus_req), 0); cyc();
    dbus_ack = 1; dbus_rdata = 32'hCAFE_0001;
    mid();
    check("ml_req", 32'(dbus_req), 1);
    check("ml_addr", dbus_addr, 32'h84);
    check("ml_ack_stall", 32'(mem_stall), 0);
    cyc();
    clr(); wr = 1; wr_addr = 32'h88; wr_data = 32'h55;
    mid();
    check("b2b_gap_req", 32'(dbus_req), 0);
    check("b2b_stall", 32'(mem_stall), 1);
    check("ml_wb_data", wb_data, 32'hCAFE_0001);
    check("ml_wb_wr", 32'(wb_reg_wr), 1);
    check("ml_wb_addr", 32'(wb_addr), 12);
    cyc();
    dbus_ack = 1;
    mid();
    check("b2b_req", 32'(dbus_req), 1);
    check("b2b_we", 32'(dbus_we), 1);
    check("b2b_addr", dbus_addr, 32'h88);
    check("b2b_ack_stall", 32'(mem_stall), 0);
    cyc();
    clr();
    mid(); check("b2b_req_drop", 32'(dbus_req), 0); check("b2b_no_fault", 32'(mem_fault), 0); cyc();
    $display("load 0x84 then store 0x88 back-to-back");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
